// File: rtl/faerie_alu_mc.sv
// faerie_alu_mc: multi-cycle ALU with a valid/ready handshake on both sides.
// Accepts one operation at a time. The result is held in an output register
// until it is consumed.
// Optional build macro FAERIE_ALU_MC_FASTSHIFT_EN: ops 8-10 use a
// combinational barrel shifter and complete in one cycle.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - request handshake; op/use_c/cin/a/b are captured here
//   out_valid/out_ready - result handshake; q/cout/err are held until consumed
module faerie_alu_mc #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             use_c,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             err
);

  localparam int unsigned CW        = $clog2(WIDTH);
  localparam int unsigned CNTW      = CW + 1;
  localparam int unsigned W1        = WIDTH + 1;
  localparam int unsigned PW        = WIDTH + MUL_BITS;
  localparam int unsigned AW        = 2 * WIDTH;
  localparam int unsigned MUL_STEPS = WIDTH / MUL_BITS;

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3,  OP_XOR  = 4'd4,  OP_PASB = 4'd5;
  localparam logic [3:0] OP_SHR1 = 4'd6,  OP_SHL1 = 4'd7,  OP_SHLN = 4'd8;
  localparam logic [3:0] OP_SHRN = 4'd9,  OP_ASRN = 4'd10, OP_MUL  = 4'd11;
  localparam logic [3:0] OP_MULH = 4'd12;

`ifdef FAERIE_ALU_MC_FASTSHIFT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd2} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, MUL = 2'd2} state_e;
`endif

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sh_q, sh_d;       // shift data, or multiplicand during MUL
  logic [AW-1:0]     acc_q, acc_d;     // {partial high, remaining multiplier}
  logic [CNTW-1:0]   cnt_q, cnt_d;     // steps remaining
  logic [3:0]        op_q, op_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              cout_q, cout_d, err_q, err_d;

  logic              accept, is_mul_in, multi_in, cin_add, cin_sub, fill;
  logic [CW-1:0]     cnt_in;
  logic [W1-1:0]     add_s, sub_s;
  logic [WIDTH-1:0]  r_q, fin_q, w_sh, st_sh;
  logic              r_c, r_err, fin_c, st_c, last;
  logic [3:0]        w_op;
  logic [AW-1:0]     w_acc, st_acc;
  logic [CNTW-1:0]   w_cnt;
  logic [PW-1:0]     part;

  assign in_ready  = (state_q == IDLE) & (~out_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign cout      = cout_q;
  assign err       = err_q;

  assign cnt_in    = b[CW-1:0];
  assign is_mul_in = (op == OP_MUL) | (op == OP_MULH);
  assign cin_add   = use_c ? cin : 1'b0;
  assign cin_sub   = use_c ? cin : 1'b1;
  assign fill      = use_c & cin;
  assign add_s     = {1'b0, a} + {1'b0, b} + W1'(cin_add);
  assign sub_s     = {1'b0, a} + {1'b0, ~b} + W1'(cin_sub);

`ifdef FAERIE_ALU_MC_FASTSHIFT_EN
  logic [W1-1:0] bsl, bsr, bsa;
  // Extra bit beside the data catches the last bit shifted out.
  assign bsl      = {1'b0, a} << cnt_in;
  assign bsr      = {a, 1'b0} >> cnt_in;
  assign bsa      = W1'($signed({a, 1'b0}) >>> cnt_in);
  assign multi_in = is_mul_in;
`else
  logic is_shift_in;
  assign is_shift_in = (op == OP_SHLN) | (op == OP_SHRN) | (op == OP_ASRN);
  assign multi_in    = is_mul_in | (is_shift_in & (cnt_in != '0));
`endif

  // Single-cycle result straight from the live inputs
  always_comb begin
    r_q   = '0;
    r_c   = 1'b0;
    r_err = 1'b0;
    case (op)
      OP_ADD:  {r_c, r_q} = add_s;
      OP_SUB:  {r_c, r_q} = sub_s;
      OP_AND:  begin r_q = a & b; r_c = b[0]; end
      OP_OR:   begin r_q = a | b; r_c = b[0]; end
      OP_XOR:  begin r_q = a ^ b; r_c = b[0]; end
      OP_PASB: begin r_q = b;     r_c = b[0]; end
      OP_SHR1: begin r_q = {fill, a[WIDTH-1:1]}; r_c = a[0]; end
      OP_SHL1: begin r_q = {a[WIDTH-2:0], fill}; r_c = a[WIDTH-1]; end
      OP_SHLN, OP_SHRN, OP_ASRN: begin
        r_q = a;
        r_c = cin;
`ifdef FAERIE_ALU_MC_FASTSHIFT_EN
        if (cnt_in != '0) begin
          if (op == OP_SHLN)      {r_c, r_q} = bsl;
          else if (op == OP_SHRN) {r_q, r_c} = bsr;
          else                    {r_q, r_c} = bsa;
        end
`endif
      end
      OP_MUL, OP_MULH: ;
      default: r_err = 1'b1;
    endcase
  end

  // Iterative step: on the accept edge it works on the live inputs so the
  // first step overlaps acceptance; afterwards it works on captured state.
  always_comb begin
    if (state_q == IDLE) begin
      w_op  = op;
      w_sh  = a;
      w_acc = {WIDTH'(0), b};
      w_cnt = is_mul_in ? CNTW'(MUL_STEPS) : {1'b0, cnt_in};
    end else begin
      w_op  = op_q;
      w_sh  = sh_q;
      w_acc = acc_q;
      w_cnt = cnt_q;
    end

    st_sh = w_sh;
    st_c  = 1'b0;
`ifndef FAERIE_ALU_MC_FASTSHIFT_EN
    case (w_op)
      OP_SHLN: begin st_sh = {w_sh[WIDTH-2:0], 1'b0};        st_c = w_sh[WIDTH-1]; end
      OP_SHRN: begin st_sh = {1'b0, w_sh[WIDTH-1:1]};        st_c = w_sh[0]; end
      OP_ASRN: begin st_sh = {w_sh[WIDTH-1], w_sh[WIDTH-1:1]}; st_c = w_sh[0]; end
      default: ;
    endcase
`endif

    // Shift-add: add multiplicand * low multiplier bits into the high half,
    // then shift the whole accumulator right by MUL_BITS.
    part   = PW'(w_acc[AW-1:WIDTH]) + PW'(w_sh) * PW'(w_acc[MUL_BITS-1:0]);
    st_acc = AW'({part, w_acc[WIDTH-1:0]} >> MUL_BITS);
    last   = (w_cnt == CNTW'(1));

    case (w_op)
      OP_MUL:  begin fin_q = st_acc[WIDTH-1:0];  fin_c = |st_acc[AW-1:WIDTH]; end
      OP_MULH: begin fin_q = st_acc[AW-1:WIDTH]; fin_c = |st_acc[WIDTH-1:0]; end
      default: begin fin_q = st_sh;              fin_c = st_c; end
    endcase
  end

  // Next state and output register
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    q_d         = q_q;
    cout_d      = cout_q;
    err_d       = err_q;
    out_valid_d = out_valid_q & ~out_ready;

    if (state_q == IDLE) begin
      if (accept) begin
        if (!multi_in) begin
          out_valid_d = 1'b1;
          q_d         = r_q;
          cout_d      = r_c;
          err_d       = r_err;
        end else if (last) begin
          out_valid_d = 1'b1;
          q_d         = fin_q;
          cout_d      = fin_c;
          err_d       = 1'b0;
        end else begin
`ifdef FAERIE_ALU_MC_FASTSHIFT_EN
          state_d = MUL;
`else
          state_d = is_mul_in ? MUL : SHIFT;
`endif
          sh_d    = is_mul_in ? w_sh : st_sh;
          acc_d   = st_acc;
          cnt_d   = w_cnt - CNTW'(1);
          op_d    = op;
        end
      end
    end else begin
      sh_d  = (state_q == MUL) ? w_sh : st_sh;
      acc_d = st_acc;
      cnt_d = w_cnt - CNTW'(1);
      if (last) begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        q_d         = fin_q;
        cout_d      = fin_c;
        err_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      cout_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      q_q         <= q_d;
      cout_q      <= cout_d;
      err_q       <= err_d;
    end
  end

endmodule
